// File: rtl/ac_pkg.sv
// Shared types for the accumulator: default width and the operation select
// produced by the strobe priority encoder.
package ac_pkg;

    localparam int AC_WIDTH = 8;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_CLR,
        OP_LD,
        OP_ADD,
        OP_SUB,
        OP_INC
    } op_t;

    // Strobe priority, highest first: clr > ld > add > sub > inc.
    function automatic op_t sel_op(
        input logic clr,
        input logic ld,
        input logic add,
        input logic sub,
        input logic inc
    );
        if (clr)      return OP_CLR;
        else if (ld)  return OP_LD;
        else if (add) return OP_ADD;
        else if (sub) return OP_SUB;
        else if (inc) return OP_INC;
        else          return OP_NONE;
    endfunction

endpackage

// File: rtl/ac_addsub.sv
// Combinational WIDTH-bit adder with carry-in; the caller inverts b and sets
// cin for subtract, or zeroes b and sets cin for increment.
module ac_addsub #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf
);

    logic [WIDTH:0] full;

    assign full  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign sum   = full[WIDTH-1:0];
    assign carry = full[WIDTH];
    // Signed overflow: operands agree in sign, result does not.
    assign ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/ac.sv
// Accumulator register: load, clear, add, subtract and increment with
// registered carry/overflow and combinational zero/negative flags.
module ac
    import ac_pkg::*;
#(
    parameter int WIDTH = AC_WIDTH
) (
    input  logic [WIDTH-1:0] data_in,
    input  logic             ld_ac,
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] ac_out,
    input  logic             add_ac,
    input  logic             sub_ac,
    input  logic             inc_ac,
    input  logic             clr_ac,
    output logic             carry,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    op_t             op;
    logic [WIDTH-1:0] b_opnd;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             as_carry;
    logic             as_ovf;

    assign op = sel_op(clr_ac, ld_ac, add_ac, sub_ac, inc_ac);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        b_opnd = data_in;
        cin    = 1'b0;
        case (op)
            OP_SUB: begin
                b_opnd = ~data_in;
                cin    = 1'b1;
            end
            OP_INC: begin
                b_opnd = '0;
                cin    = 1'b1;
            end
            default: ;
        endcase
    end

    ac_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a     (ac_out),
        .b     (b_opnd),
        .cin   (cin),
        .sum   (sum),
        .carry (as_carry),
        .ovf   (as_ovf)
    );

    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ac_out <= '0;
            carry  <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (op)
                OP_CLR: begin
                    ac_out <= '0;
                    carry  <= 1'b0;
                    ovf    <= 1'b0;
                end
                OP_LD: begin
                    ac_out <= data_in;
                    carry  <= 1'b0;
                    ovf    <= 1'b0;
                end
                OP_ADD, OP_SUB, OP_INC: begin
                    ac_out <= sum;
                    carry  <= as_carry;
                    ovf    <= as_ovf;
                end
                default: ;
            endcase
        end
    end

    assign zero = (ac_out == '0);
    assign neg  = ac_out[WIDTH-1];

endmodule

// File: tb/tb_ac.sv
// Scoreboard bench for ac: each stimulus step queues its hand-computed result,
// and a monitor compares the registered state on the following falling edge.
module tb_ac;

    localparam int W = 8;

    typedef struct {
        string        name;
        logic [W-1:0] ac;
        logic         c;
        logic         z;
        logic         n;
        logic         v;
    } exp_t;

    logic [W-1:0] data_in;
    logic         ld_ac, clk, rst, add_ac, sub_ac, inc_ac, clr_ac;
    logic [W-1:0] ac_out;
    logic         carry, zero, neg, ovf;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    ac #(.WIDTH(W)) dut (
        .data_in (data_in),
        .ld_ac   (ld_ac),
        .clk     (clk),
        .rst     (rst),
        .ac_out  (ac_out),
        .add_ac  (add_ac),
        .sub_ac  (sub_ac),
        .inc_ac  (inc_ac),
        .clr_ac  (clr_ac),
        .carry   (carry),
        .zero    (zero),
        .neg     (neg),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // Monitor: compares the post-edge state for every queued step.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.name, ".ac"},    32'(ac_out), 32'(e.ac));
                check({e.name, ".carry"}, 32'(carry),  32'(e.c));
                check({e.name, ".zero"},  32'(zero),   32'(e.z));
                check({e.name, ".neg"},   32'(neg),    32'(e.n));
                check({e.name, ".ovf"},   32'(ovf),    32'(e.v));
            end
        end
    end

    // One clock step: drive controls, take the edge, queue the expected state.
    task automatic step(
        input string        name,
        input logic [5:0]   ctl,      // {rst, clr, ld, add, sub, inc}
        input logic [W-1:0] d,
        input logic [W-1:0] eac,
        input logic         ec,
        input logic         ev
    );
        exp_t e;
        @(negedge clk);
        {rst, clr_ac, ld_ac, add_ac, sub_ac, inc_ac} = ctl;
        data_in = d;
        @(posedge clk);
        e.name = name;
        e.ac   = eac;
        e.c    = ec;
        e.z    = (eac == '0);
        e.n    = eac[W-1];
        e.v    = ev;
        exp_q.push_back(e);
    endtask

    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] RST  = 6'b100000;
    localparam logic [5:0] CLR  = 6'b010000;
    localparam logic [5:0] LD   = 6'b001000;
    localparam logic [5:0] ADD  = 6'b000100;
    localparam logic [5:0] SUB  = 6'b000010;
    localparam logic [5:0] INC  = 6'b000001;

    initial begin
        {rst, clr_ac, ld_ac, add_ac, sub_ac, inc_ac} = 6'b0;
        data_in = '0;

        step("reset_with_ld",  RST | LD,  8'hFF, 8'h00, 1'b0, 1'b0);
        step("ld_a5",          LD,        8'hA5, 8'hA5, 1'b0, 1'b0);
        step("ld_3c",          LD,        8'h3C, 8'h3C, 1'b0, 1'b0);
        step("hold_3c",        NONE,      8'h99, 8'h3C, 1'b0, 1'b0);
        step("ld_7f",          LD,        8'h7F, 8'h7F, 1'b0, 1'b0);
        step("add_7f_01",      ADD,       8'h01, 8'h80, 1'b0, 1'b1);
        step("hold_flags",     NONE,      8'h00, 8'h80, 1'b0, 1'b1);
        step("add_80_80",      ADD,       8'h80, 8'h00, 1'b1, 1'b1);
        step("ld_05",          LD,        8'h05, 8'h05, 1'b0, 1'b0);
        step("sub_05_07",      SUB,       8'h07, 8'hFE, 1'b0, 1'b0);
        step("ld_07",          LD,        8'h07, 8'h07, 1'b0, 1'b0);
        step("sub_07_05",      SUB,       8'h05, 8'h02, 1'b1, 1'b0);
        step("ld_80",          LD,        8'h80, 8'h80, 1'b0, 1'b0);
        step("sub_80_01",      SUB,       8'h01, 8'h7F, 1'b1, 1'b1);
        step("inc_7f",         INC,       8'h00, 8'h80, 1'b0, 1'b1);
        step("ld_ff",          LD,        8'hFF, 8'hFF, 1'b0, 1'b0);
        step("inc_ff_wrap",    INC,       8'h00, 8'h00, 1'b1, 1'b0);
        step("ld_3c_b",        LD,        8'h3C, 8'h3C, 1'b0, 1'b0);
        step("prio_clr",       CLR | LD | ADD, 8'h55, 8'h00, 1'b0, 1'b0);
        step("prio_ld",        LD | ADD,  8'h11, 8'h11, 1'b0, 1'b0);
        step("prio_add",       ADD | SUB | INC, 8'h02, 8'h13, 1'b0, 1'b0);
        step("prio_sub",       SUB | INC, 8'h03, 8'h10, 1'b1, 1'b0);
        step("rst_mid",        RST | ADD | INC, 8'h01, 8'h00, 1'b0, 1'b0);
        step("after_rst_hold", NONE,      8'h01, 8'h00, 1'b0, 1'b0);

        @(negedge clk);
        {rst, clr_ac, ld_ac, add_ac, sub_ac, inc_ac} = 6'b0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
